tcdm_bank: RTL and testbench



---
 rtl/tcdm_bank.sv | 124 ++++++++++++
 tb/tb_tcdm_bank.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcdm_bank.sv
// Single-port TCDM bank responder: byte-enabled word array, fixed-latency read
// response pipeline, optional post-reset zero sweep and saturating access counters.
module tcdm_bank #(
  parameter int AddrMemWidth = 12,
  parameter int DataWidth    = 32,
  parameter int BeWidth      = DataWidth / 8,
  parameter int RespLat      = 1,
  parameter bit ZeroInit     = 1'b1,
  parameter int CntWidth     = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [AddrMemWidth-1:0] add_i,
  input  logic                    wen_i,
  input  logic [DataWidth-1:0]    wdata_i,
  input  logic [BeWidth-1:0]      be_i,
  output logic [DataWidth-1:0]    rdata_o,
  input  logic                    stall_i,
  output logic                    init_done_o,
  input  logic                    clr_cnt_i,
  output logic [CntWidth-1:0]     rd_cnt_o,
  output logic [CntWidth-1:0]     wr_cnt_o,
  output logic [CntWidth-1:0]     stall_cnt_o
);

  localparam int NumWords = 2 ** AddrMemWidth;

  typedef enum logic {INIT, READY} state_t;

  state_t                  state_reg;
  logic [AddrMemWidth-1:0] sweep_reg;
  logic [DataWidth-1:0]    mem [NumWords];
  logic [DataWidth-1:0]    pipe_reg [RespLat];

  logic                    ready;
  logic                    gnt;
  logic                    load;
  logic                    store;
  logic                    stalled;
  logic                    init_wr;
  logic                    mem_we;
  logic [AddrMemWidth-1:0] mem_addr;
  logic [DataWidth-1:0]    mem_wdata;
  logic [BeWidth-1:0]      mem_be;
  logic [2:0]              cnt_event;

  assign ready   = (state_reg == READY);
  // Reset also blocks the grant so a ZeroInit=0 bank stays silent while held in reset.
  assign gnt     = req_i & ~stall_i & ready & ~rst_i;
  assign load    = gnt & ~wen_i;
  assign store   = gnt & wen_i;
  assign stalled = ready & req_i & ~gnt;

  assign gnt_o       = gnt;
  assign init_done_o = ready;
  assign rdata_o     = pipe_reg[RespLat-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ZeroInit ? INIT : READY;
      sweep_reg <= '0;
    end else if (state_reg == INIT) begin
      sweep_reg <= sweep_reg + 1'b1;
      if (&sweep_reg) begin
        state_reg <= READY;
      end
    end
  end

  // The zero sweep and normal stores share the single write port.
  assign init_wr   = (state_reg == INIT) & ~rst_i;
  assign mem_we    = init_wr | store;
  assign mem_addr  = init_wr ? sweep_reg : add_i;
  assign mem_wdata = init_wr ? '0 : wdata_i;
  assign mem_be    = init_wr ? '1 : be_i;

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < BeWidth; b++) begin
        if (mem_be[b]) begin
          mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  // Stage 0 is the registered array read; idle cycles inject zero so rdata_o is
  // nonzero only in the cycle a response is due.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < RespLat; s++) begin
        pipe_reg[s] <= '0;
      end
    end else begin
      pipe_reg[0] <= load ? mem[add_i] : '0;
      for (int s = 1; s < RespLat; s++) begin
        pipe_reg[s] <= pipe_reg[s-1];
      end
    end
  end

  assign cnt_event = {stalled, store, load};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cnt
      logic [CntWidth-1:0] cnt_reg;
      always_ff @(posedge clk_i) begin
        if (rst_i || clr_cnt_i) begin
          cnt_reg <= '0;
        end else if (cnt_event[gi] && !(&cnt_reg)) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  endgenerate

  assign rd_cnt_o    = g_cnt[0].cnt_reg;
  assign wr_cnt_o    = g_cnt[1].cnt_reg;
  assign stall_cnt_o = g_cnt[2].cnt_reg;

endmodule

// File: tb/tb_tcdm_bank.sv
// Drives two banks from shared inputs (A: RespLat=1, zero-init, 32-bit counters;
// B: RespLat=3, no zero-init, 3-bit counters) and checks both against a cycle model.
module tb_tcdm_bank;

  logic        clk = 1'b0;
  logic        rst, req, wen, stall, clr;
  logic [3:0]  add, be;
  logic [31:0] wdata;

  logic        gnt_a, init_done_a, gnt_b, init_done_b;
  logic [31:0] rdata_a, rdata_b;
  logic [31:0] rd_cnt_a, wr_cnt_a, st_cnt_a;
  logic [2:0]  rd_cnt_b, wr_cnt_b, st_cnt_b;

  always #5 clk = ~clk;

  tcdm_bank #(.AddrMemWidth(4), .DataWidth(32), .RespLat(1), .ZeroInit(1'b1), .CntWidth(32)) dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt_a), .add_i(add), .wen_i(wen),
    .wdata_i(wdata), .be_i(be), .rdata_o(rdata_a), .stall_i(stall), .init_done_o(init_done_a),
    .clr_cnt_i(clr), .rd_cnt_o(rd_cnt_a), .wr_cnt_o(wr_cnt_a), .stall_cnt_o(st_cnt_a)
  );

  tcdm_bank #(.AddrMemWidth(4), .DataWidth(32), .RespLat(3), .ZeroInit(1'b0), .CntWidth(3)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt_b), .add_i(add), .wen_i(wen),
    .wdata_i(wdata), .be_i(be), .rdata_o(rdata_b), .stall_i(stall), .init_done_o(init_done_b),
    .clr_cnt_i(clr), .rd_cnt_o(rd_cnt_b), .wr_cnt_o(wr_cnt_b), .stall_cnt_o(st_cnt_b)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          lat_m  [2] = '{1, 3};
  bit          zi_m   [2] = '{1'b1, 1'b0};
  longint      cmax_m [2] = '{64'hFFFF_FFFF, 7};
  logic [31:0] mem_m  [2][16];
  logic [3:0]  kn_m   [2][16];
  bit          rdy_m  [2];
  int          since_m[2];
  longint      rd_m[2], wr_m[2], st_m[2];
  logic [31:0] rv_m   [2][8];
  bit          rvld_m [2][8];
  bit          rkn_m  [2][8];
  int          cyc = 0;
  bit          live = 1'b0;

  initial begin
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 16; w++) kn_m[d][w] = 4'h0;
  end

  function automatic longint sat_inc(input longint v, input longint mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic model_check();
    logic        g;
    logic [31:0] act_rd, act_wr, act_st, act_rdata;
    logic        act_gnt, act_done;
    int          slot;
    string       nm;
    if (!live) return;
    slot = cyc % 8;
    for (int d = 0; d < 2; d++) begin
      nm       = (d == 0) ? "a" : "b";
      g        = req & ~stall & rdy_m[d] & ~rst;
      act_gnt  = (d == 0) ? gnt_a : gnt_b;
      act_done = (d == 0) ? init_done_a : init_done_b;
      act_rdata = (d == 0) ? rdata_a : rdata_b;
      act_rd   = (d == 0) ? rd_cnt_a : {29'b0, rd_cnt_b};
      act_wr   = (d == 0) ? wr_cnt_a : {29'b0, wr_cnt_b};
      act_st   = (d == 0) ? st_cnt_a : {29'b0, st_cnt_b};
      check($sformatf("m_gnt_%s", nm), {31'b0, act_gnt}, {31'b0, g});
      check($sformatf("m_init_done_%s", nm), {31'b0, act_done}, {31'b0, rdy_m[d]});
      check($sformatf("m_rd_cnt_%s", nm), act_rd, rd_m[d][31:0]);
      check($sformatf("m_wr_cnt_%s", nm), act_wr, wr_m[d][31:0]);
      check($sformatf("m_stall_cnt_%s", nm), act_st, st_m[d][31:0]);
      if (!rvld_m[d][slot])
        check($sformatf("m_rdata_%s", nm), act_rdata, 32'h0);
      else if (rkn_m[d][slot])
        check($sformatf("m_rdata_%s", nm), act_rdata, rv_m[d][slot]);
    end
  endtask

  // Advances the model over the clock edge that ends the current cycle.
  task automatic model_step();
    bit g;
    int s;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        rdy_m[d] = !zi_m[d];
        since_m[d] = 0;
        rd_m[d] = 0; wr_m[d] = 0; st_m[d] = 0;
        for (int k = 0; k < 8; k++) rvld_m[d][k] = 1'b0;
        if (zi_m[d])
          for (int w = 0; w < 16; w++) begin mem_m[d][w] = 32'h0; kn_m[d][w] = 4'hF; end
      end else begin
        g = req & ~stall & rdy_m[d];
        rvld_m[d][cyc % 8] = 1'b0;
        if (clr) begin
          rd_m[d] = 0; wr_m[d] = 0; st_m[d] = 0;
        end else begin
          if (g && wen)  wr_m[d] = sat_inc(wr_m[d], cmax_m[d]);
          if (g && !wen) rd_m[d] = sat_inc(rd_m[d], cmax_m[d]);
          if (rdy_m[d] && req && !g) st_m[d] = sat_inc(st_m[d], cmax_m[d]);
        end
        if (g && !wen) begin
          s = (cyc + lat_m[d]) % 8;
          rvld_m[d][s] = 1'b1;
          rv_m[d][s]   = mem_m[d][add];
          rkn_m[d][s]  = (kn_m[d][add] == 4'hF);
        end
        if (g && wen)
          for (int b = 0; b < 4; b++)
            if (be[b]) begin
              mem_m[d][add][8*b +: 8] = wdata[8*b +: 8];
              kn_m[d][add][b] = 1'b1;
            end
        if (!rdy_m[d]) begin
          since_m[d]++;
          if (since_m[d] == 16) rdy_m[d] = 1'b1;
        end
      end
    end
    cyc++;
    live = 1'b1;
  endtask

  // Inputs change 1 time unit after posedge; outputs are sampled on negedge.
  task automatic apply(input logic r, input logic w, input logic [3:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic s, input logic c, input logic rs);
    req = r; wen = w; add = a; wdata = d; be = b; stall = s; clr = c; rst = rs;
    @(negedge clk);
    model_check();
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    apply(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- directed vector table (expectations for bank A) ----------------
  typedef struct {
    logic        req, wen;
    logic [3:0]  add;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        stall;
    logic        exp_gnt;
    logic [31:0] exp_rdata;
    int          exp_wr, exp_rd, exp_st;
  } vec_t;

  vec_t tbl[$];

  task automatic vec(input logic r, input logic w, input logic [3:0] a, input logic [31:0] d,
                     input logic [3:0] b, input logic s, input logic eg, input logic [31:0] er,
                     input int ewr, input int erd, input int est);
    vec_t v;
    v.req = r; v.wen = w; v.add = a; v.wdata = d; v.be = b; v.stall = s;
    v.exp_gnt = eg; v.exp_rdata = er; v.exp_wr = ewr; v.exp_rd = erd; v.exp_st = est;
    tbl.push_back(v);
  endtask

  initial begin
    // byte-enable write and readback
    vec(1, 1, 3, 32'hAABBCCDD, 4'hF, 0, 1, 32'h0,        0, 0, 0);
    vec(1, 1, 3, 32'h11223344, 4'h5, 0, 1, 32'h0,        1, 0, 0);
    vec(1, 0, 3, 32'h0,        4'h0, 0, 1, 32'h0,        2, 0, 0);
    vec(0, 0, 0, 32'h0,        4'h0, 0, 0, 32'hAA22CC44, 2, 1, 0);
    // latency: pre-write 0..2, then back-to-back loads
    vec(1, 1, 0, 32'hA0,       4'hF, 0, 1, 32'h0,        2, 1, 0);
    vec(1, 1, 1, 32'hA1,       4'hF, 0, 1, 32'h0,        3, 1, 0);
    vec(1, 1, 2, 32'hA2,       4'hF, 0, 1, 32'h0,        4, 1, 0);
    vec(1, 0, 0, 32'h0,        4'h0, 0, 1, 32'h0,        5, 1, 0);
    vec(1, 0, 1, 32'h0,        4'h0, 0, 1, 32'hA0,       5, 2, 0);
    vec(1, 0, 2, 32'h0,        4'h0, 0, 1, 32'hA1,       5, 3, 0);
    vec(0, 0, 0, 32'h0,        4'h0, 0, 0, 32'hA2,       5, 4, 0);
    vec(0, 0, 0, 32'h0,        4'h0, 0, 0, 32'h0,        5, 4, 0);
    // throttling: load just before stall, 4 stalled cycles, grant on release
    vec(1, 0, 3, 32'h0,        4'h0, 0, 1, 32'h0,        5, 4, 0);
    vec(1, 0, 0, 32'h0,        4'h0, 1, 0, 32'hAA22CC44, 5, 5, 0);
    vec(1, 0, 0, 32'h0,        4'h0, 1, 0, 32'h0,        5, 5, 1);
    vec(1, 0, 0, 32'h0,        4'h0, 1, 0, 32'h0,        5, 5, 2);
    vec(1, 0, 0, 32'h0,        4'h0, 1, 0, 32'h0,        5, 5, 3);
    vec(1, 0, 0, 32'h0,        4'h0, 0, 1, 32'h0,        5, 5, 4);
    vec(0, 0, 0, 32'h0,        4'h0, 0, 0, 32'hA0,       5, 6, 4);
    vec(0, 0, 0, 32'h0,        4'h0, 0, 0, 32'h0,        5, 6, 4);

    // reset
    req = 0; wen = 0; add = 0; wdata = 0; be = 0; stall = 0; clr = 0; rst = 1;
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
      if (i > 0) begin
        check("rst_rdata_a", rdata_a, 32'h0);
        check("rst_done_a", {31'b0, init_done_a}, 32'h0);
        check("rst_done_b", {31'b0, init_done_b}, 32'h1);
        check("rst_gnt_b", {31'b0, gnt_b}, 32'h0);
      end
      advance();
    end

    // init sweep with a load held at address 5
    for (int k = 0; k < 18; k++) begin
      apply(1'b1, 1'b0, 4'h5, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      check($sformatf("init_gnt_c%0d", k), {31'b0, gnt_a}, (k >= 16) ? 32'h1 : 32'h0);
      check($sformatf("init_done_c%0d", k), {31'b0, init_done_a}, (k >= 16) ? 32'h1 : 32'h0);
      if (k == 17) check("init_rdata_c17", rdata_a, 32'h0);
      advance();
    end

    apply(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    advance();

    foreach (tbl[i]) begin
      apply(tbl[i].req, tbl[i].wen, tbl[i].add, tbl[i].wdata, tbl[i].be, tbl[i].stall, 1'b0, 1'b0);
      check($sformatf("tbl%0d_gnt", i), {31'b0, gnt_a}, {31'b0, tbl[i].exp_gnt});
      check($sformatf("tbl%0d_rdata", i), rdata_a, tbl[i].exp_rdata);
      check($sformatf("tbl%0d_wr", i), wr_cnt_a, tbl[i].exp_wr);
      check($sformatf("tbl%0d_rd", i), rd_cnt_a, tbl[i].exp_rd);
      check($sformatf("tbl%0d_st", i), st_cnt_a, tbl[i].exp_st);
      advance();
    end

    // counter saturation (B has 3-bit counters) and clear priority
    apply(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    advance();
    for (int i = 0; i < 9; i++) begin
      apply(1'b1, 1'b1, 4'(4 + i), $urandom, 4'hF, 1'b0, 1'b0, 1'b0);
      advance();
    end
    idle();
    check("sat_wr_b", {29'b0, wr_cnt_b}, 32'd7);
    check("nosat_wr_a", wr_cnt_a, 32'd9);
    advance();
    apply(1'b1, 1'b1, 4'hD, $urandom, 4'hF, 1'b0, 1'b1, 1'b0);
    advance();
    idle();
    check("clr_wr_a", wr_cnt_a, 32'd0);
    check("clr_wr_b", {29'b0, wr_cnt_b}, 32'd0);
    check("clr_rd_b", {29'b0, rd_cnt_b}, 32'd0);
    advance();

    // mid-operation reset: in-flight B response is dropped, B array retained
    apply(1'b1, 1'b1, 4'h7, 32'h5A5A1234, 4'hF, 1'b0, 1'b0, 1'b0);
    advance();
    apply(1'b1, 1'b0, 4'h7, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    advance();
    apply(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    check("mrst_rdata_b0", rdata_b, 32'h0);
    advance();
    apply(1'b1, 1'b0, 4'h7, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    check("mrst_rdata_b1", rdata_b, 32'h0);
    check("mrst_gnt_a", {31'b0, gnt_a}, 32'h0);
    check("mrst_gnt_b", {31'b0, gnt_b}, 32'h1);
    advance();
    idle();
    check("mrst_rdata_b2", rdata_b, 32'h0);
    advance();
    idle();
    check("mrst_rdata_b3", rdata_b, 32'h0);
    advance();
    idle();
    check("mrst_retained_b", rdata_b, 32'h5A5A1234);
    advance();
    for (int i = 0; i < 14; i++) begin
      idle();
      advance();
    end

    // randomized traffic checked by the model
    for (int i = 0; i < 800; i++) begin
      apply($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
            $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0,
            $urandom_range(0, 39) == 0, $urandom_range(0, 299) == 0);
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
